// File: rtl/audio_filter_pkg.sv
// Shared types for the audio filter coefficient path.
// Contents:
//   coef_t        signed Q2.14 coefficient, Q_ONE = 1.0
//   coef_idx_e    coefficient select on the config interface (b0,b1,b2,a1,a2)
//   ctrl_state_e  coefficient controller FSM states
//   coef_set_t    one complete biquad coefficient set
//   unity_set / get_coef / set_coef helpers
package audio_filter_pkg;

  typedef logic signed [15:0] coef_t;

  localparam coef_t Q_ONE = 16'sd16384;

  typedef enum logic [2:0] {
    COEF_B0 = 3'd0,
    COEF_B1 = 3'd1,
    COEF_B2 = 3'd2,
    COEF_A1 = 3'd3,
    COEF_A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    CHECK     = 2'd2,
    WAIT_TICK = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    coef_t b0;
    coef_t b1;
    coef_t b2;
    coef_t a1;
    coef_t a2;
  } coef_set_t;

  // Passthrough biquad: y = x.
  function automatic coef_set_t unity_set();
    coef_set_t s;
    s.b0 = Q_ONE;
    s.b1 = 16'sd0;
    s.b2 = 16'sd0;
    s.a1 = 16'sd0;
    s.a2 = 16'sd0;
    return s;
  endfunction

  // Select one coefficient of a set by config index.
  function automatic coef_t get_coef(input coef_set_t s, input logic [2:0] idx);
    coef_t c;
    case (idx)
      COEF_B0: c = s.b0;
      COEF_B1: c = s.b1;
      COEF_B2: c = s.b2;
      COEF_A1: c = s.a1;
      COEF_A2: c = s.a2;
      default: c = s.b0;
    endcase
    return c;
  endfunction

  // Return a copy of a set with one coefficient replaced; indices above a2 leave it untouched.
  function automatic coef_set_t set_coef(input coef_set_t s, input logic [2:0] idx,
                                         input coef_t val);
    coef_set_t r;
    r = s;
    case (idx)
      COEF_B0: r.b0 = val;
      COEF_B1: r.b1 = val;
      COEF_B2: r.b2 = val;
      COEF_A1: r.a1 = val;
      COEF_A2: r.a2 = val;
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/coeff_stability_check.sv
// Combinational stability test for a biquad denominator 1 + a1 z^-1 + a2 z^-2.
// Ports:
//   a1, a2  in  signed Q2.14 feedback coefficients
//   stable  out 1 when the poles lie strictly inside the unit circle
// The stability triangle is evaluated in 18-bit signed arithmetic so that
// |a1| of -32768 and Q_ONE + a2 never overflow.
module coeff_stability_check
  import audio_filter_pkg::*;
(
  input  coef_t a1,
  input  coef_t a2,
  output logic  stable
);

  logic signed [17:0] a1_x;
  logic signed [17:0] a2_x;
  logic signed [17:0] a1_abs;
  logic signed [17:0] lim;

  // Stability triangle: |a2| < 1 and |a1| < 1 + a2.
  always_comb begin
    a1_x   = {{2{a1[15]}}, a1};
    a2_x   = {{2{a2[15]}}, a2};
    if (a1_x[17]) begin
      a1_abs = -a1_x;
    end else begin
      a1_abs = a1_x;
    end
    lim    = 18'sd16384 + a2_x;
    stable = (a2_x < 18'sd16384) && (a2_x > -18'sd16384) && (a1_abs < lim);
  end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient controller for the 24-bit biquad.
// Holds NUM_PRESETS coefficient sets, fetches one on request, checks its
// denominator, and swaps it into the active set on a sample boundary.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cfg_we/cfg_preset/cfg_idx/cfg_data  preset bank write port
//   cfg_wr_err                      pulse: write dropped (target preset is loading)
//   load_req/load_preset            request to apply a preset
//   sample_tick                     one strobe per audio sample
//   b0,b1,b2,a1,a2                  active coefficients (registered)
//   filter_clear/load_ack           pulses on the cycle after a swap
//   load_err                        pulse: preset rejected as unstable
//   busy                            controller not idle
//   active_preset                   index of the applied preset
module iir_coeff_ctrl
  import audio_filter_pkg::*;
#(
  parameter int NUM_PRESETS = 4,
  parameter int PW          = $clog2(NUM_PRESETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [PW-1:0]        cfg_preset,
  input  logic [2:0]           cfg_idx,
  input  logic signed [15:0]   cfg_data,
  output logic                 cfg_wr_err,
  input  logic                 load_req,
  input  logic [PW-1:0]        load_preset,
  input  logic                 sample_tick,
  output logic signed [15:0]   b0,
  output logic signed [15:0]   b1,
  output logic signed [15:0]   b2,
  output logic signed [15:0]   a1,
  output logic signed [15:0]   a2,
  output logic                 filter_clear,
  output logic                 load_ack,
  output logic                 load_err,
  output logic                 busy,
  output logic [PW-1:0]        active_preset
);

  ctrl_state_e      state_q, state_d;
  logic [2:0]       fetch_cnt_q, fetch_cnt_d;
  logic [PW-1:0]    load_preset_q, load_preset_d;
  logic [PW-1:0]    active_preset_q, active_preset_d;
  coef_set_t        stage_q, stage_d;
  coef_set_t        act_q, act_d;
  logic             ack_q, ack_d;
  logic             clear_q, clear_d;
  logic             err_q, err_d;
  logic             wr_err_q, wr_err_d;
  logic             busy_q, busy_d;

  coef_set_t        bank_q [NUM_PRESETS];
  coef_set_t        rd_set_s;
  logic             stable_s;
  logic             wr_hit_s;
  logic             wr_block_s;

  coeff_stability_check u_stab (
    .a1     (stage_q.a1),
    .a2     (stage_q.a2),
    .stable (stable_s)
  );

  // Single read port of the bank, addressed by the preset being loaded.
  assign rd_set_s   = bank_q[load_preset_q];
  // Indices 5-7 are not coefficients: such writes neither land nor raise an error.
  assign wr_hit_s   = cfg_we && (cfg_idx <= 3'd4);
  // The preset under load is frozen so the fetched and applied sets agree.
  assign wr_block_s = wr_hit_s && busy_q && (cfg_preset == load_preset_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (fetch_cnt_q == 3'd4) begin
          state_d = CHECK;
        end else begin
          state_d = FETCH;
        end
      end
      CHECK: begin
        if (stable_s) begin
          state_d = WAIT_TICK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_TICK: begin
        if (sample_tick) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and pulse next values per state.
  always_comb begin
    fetch_cnt_d     = fetch_cnt_q;
    load_preset_d   = load_preset_q;
    active_preset_d = active_preset_q;
    stage_d         = stage_q;
    act_d           = act_q;
    ack_d           = 1'b0;
    clear_d         = 1'b0;
    err_d           = 1'b0;
    wr_err_d        = wr_block_s;
    busy_d          = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (load_req) begin
          load_preset_d = load_preset;
          fetch_cnt_d   = 3'd0;
        end else begin
          fetch_cnt_d   = fetch_cnt_q;
        end
      end
      FETCH: begin
        // One coefficient per cycle, b0 first, a2 last.
        stage_d     = set_coef(stage_q, fetch_cnt_q, get_coef(rd_set_s, fetch_cnt_q));
        fetch_cnt_d = fetch_cnt_q + 3'd1;
      end
      CHECK: begin
        if (!stable_s) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      WAIT_TICK: begin
        // All five coefficients move together on the tick edge.
        if (sample_tick) begin
          act_d           = stage_q;
          active_preset_d = load_preset_q;
          ack_d           = 1'b1;
          clear_d         = 1'b1;
        end else begin
          act_d           = act_q;
        end
      end
      default: begin
        fetch_cnt_d = 3'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q     <= 3'd0;
      load_preset_q   <= '0;
      active_preset_q <= '0;
      stage_q         <= unity_set();
      act_q           <= unity_set();
      ack_q           <= 1'b0;
      clear_q         <= 1'b0;
      err_q           <= 1'b0;
      wr_err_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      fetch_cnt_q     <= fetch_cnt_d;
      load_preset_q   <= load_preset_d;
      active_preset_q <= active_preset_d;
      stage_q         <= stage_d;
      act_q           <= act_d;
      ack_q           <= ack_d;
      clear_q         <= clear_d;
      err_q           <= err_d;
      wr_err_q        <= wr_err_d;
      busy_q          <= busy_d;
    end
  end

  // Preset bank write port; reset restores every preset to passthrough.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PRESETS; i++) begin
        bank_q[i] <= unity_set();
      end
    end else if (wr_hit_s && !wr_block_s) begin
      bank_q[cfg_preset] <= set_coef(bank_q[cfg_preset], cfg_idx, cfg_data);
    end
  end

  assign b0            = act_q.b0;
  assign b1            = act_q.b1;
  assign b2            = act_q.b2;
  assign a1            = act_q.a1;
  assign a2            = act_q.a2;
  assign load_ack      = ack_q;
  assign filter_clear  = clear_q;
  assign load_err      = err_q;
  assign cfg_wr_err    = wr_err_q;
  assign busy          = busy_q;
  assign active_preset = active_preset_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Self-checking bench for iir_coeff_ctrl: directed scenarios from the test
// plan followed by a randomized run, all against a cycle-count reference model.
module tb_iir_coeff_ctrl;

  localparam int NP = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic                cfg_we = 1'b0;
  logic [PW-1:0]       cfg_preset = '0;
  logic [2:0]          cfg_idx = 3'd0;
  logic [15:0]         cfg_data = 16'd0;
  logic                load_req = 1'b0;
  logic [PW-1:0]       load_preset = '0;
  logic                sample_tick = 1'b0;
  logic                cfg_wr_err, filter_clear, load_ack, load_err, busy;
  logic signed [15:0]  b0, b1, b2, a1, a2;
  logic [PW-1:0]       active_preset;

  iir_coeff_ctrl #(.NUM_PRESETS(NP)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_preset(cfg_preset), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_wr_err(cfg_wr_err),
    .load_req(load_req), .load_preset(load_preset), .sample_tick(sample_tick),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .filter_clear(filter_clear), .load_ack(load_ack), .load_err(load_err),
    .busy(busy), .active_preset(active_preset)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: preset contents, applied set, and progress of a load
  // counted in cycles since the request edge.
  int m_bank [NP][5];
  int m_act  [5];
  int m_act_p;
  bit m_busy;
  int m_age;
  int m_p;
  bit e_ack, e_clr, e_err, e_wrerr;

  task automatic check_val(input string tag, input logic signed [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit stable_m(input int c1, input int c2);
    int mag;
    mag = (c1 < 0) ? -c1 : c1;
    return (c2 < 16384) && (c2 > -16384) && (mag < 16384 + c2);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_bank[p][0] = 16384;
      for (int k = 1; k < 5; k++) m_bank[p][k] = 0;
    end
    m_act[0] = 16384;
    for (int k = 1; k < 5; k++) m_act[k] = 0;
    m_act_p = 0;
    m_busy  = 1'b0;
    m_age   = 0;
    m_p     = 0;
  endtask

  // Advance the model across one clock edge using the inputs present at it.
  task automatic model_edge();
    bit hit, blk;
    e_ack = 1'b0; e_clr = 1'b0; e_err = 1'b0; e_wrerr = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      hit = cfg_we && (cfg_idx <= 3'd4);
      blk = hit && m_busy && (int'(cfg_preset) == m_p);
      e_wrerr = blk;
      if (hit && !blk) m_bank[cfg_preset][cfg_idx] = int'($signed(cfg_data));
      if (m_busy) begin
        if (m_age == 6) begin
          if (!stable_m(m_bank[m_p][3], m_bank[m_p][4])) begin
            e_err  = 1'b1;
            m_busy = 1'b0;
          end
        end else if (m_age >= 7 && sample_tick) begin
          for (int k = 0; k < 5; k++) m_act[k] = m_bank[m_p][k];
          m_act_p = m_p;
          e_ack   = 1'b1;
          e_clr   = 1'b1;
          m_busy  = 1'b0;
        end
        m_age++;
      end else if (load_req) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_p    = int'(load_preset);
      end
    end
  endtask

  // One clock: model update at the edge, compare every output 1 ns later,
  // then drop the single-cycle strobes.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("b0", b0, m_act[0]);
    check_val("b1", b1, m_act[1]);
    check_val("b2", b2, m_act[2]);
    check_val("a1", a1, m_act[3]);
    check_val("a2", a2, m_act[4]);
    check_val("load_ack", {31'd0, load_ack}, int'(e_ack));
    check_val("filter_clear", {31'd0, filter_clear}, int'(e_clr));
    check_val("load_err", {31'd0, load_err}, int'(e_err));
    check_val("cfg_wr_err", {31'd0, cfg_wr_err}, int'(e_wrerr));
    check_val("busy", {31'd0, busy}, int'(m_busy));
    check_val("active_preset", {30'd0, active_preset}, m_act_p);
    cfg_we      = 1'b0;
    load_req    = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic write_coef(input int p, input int idx, input int val);
    cfg_we     = 1'b1;
    cfg_preset = PW'(p);
    cfg_idx    = 3'(idx);
    cfg_data   = 16'(val);
    step();
  endtask

  task automatic write_set(input int p, input int v0, input int v1, input int v2,
                           input int v3, input int v4);
    write_coef(p, 0, v0);
    write_coef(p, 1, v1);
    write_coef(p, 2, v2);
    write_coef(p, 3, v3);
    write_coef(p, 4, v4);
  endtask

  // Request preset p at cycle 0 and tick at cycle 7; returns after cycle 8 checks.
  task automatic load_fast(input int p);
    load_req    = 1'b1;
    load_preset = PW'(p);
    step();
    for (int c = 1; c <= 7; c++) begin
      sample_tick = (c == 7);
      step();
    end
  endtask

  int rd;

  initial begin
    model_reset();
    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check_val("rst_b0", b0, 16384);
    check_val("rst_busy", {31'd0, busy}, 0);

    // Stable load of preset 1, swap visible in cycle 8
    write_set(1, 15871, -30917, 15106, -30906, 14618);
    load_fast(1);
    check_val("dir_b0", b0, 15871);
    check_val("dir_a1", a1, -30906);
    check_val("dir_ack", {31'd0, load_ack}, 1);
    check_val("dir_ap", {30'd0, active_preset}, 1);

    // Unstable a2 = 1.0: error in cycle 7, outputs unchanged
    write_set(2, 1000, 2000, 3000, 0, 16384);
    load_fast(2);
    check_val("dir_a2_rej_b0", b0, 15871);
    // |a1| equal to 1 + a2 rejects, one below accepts
    write_coef(2, 3, -31002);
    write_coef(2, 4, 14618);
    load_fast(2);
    check_val("dir_a1_rej_ap", {30'd0, active_preset}, 1);
    write_coef(2, 3, -31001);
    load_fast(2);
    check_val("dir_a1_acc_a1", a1, -31001);
    check_val("dir_a1_acc_ap", {30'd0, active_preset}, 2);

    // Write collision during a preset-1 load; preset 3 write goes through
    load_req = 1'b1; load_preset = 2'd1; step();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) begin cfg_we = 1'b1; cfg_preset = 2'd1; cfg_idx = 3'd0; cfg_data = 16'd123; end
      if (c == 3) begin cfg_we = 1'b1; cfg_preset = 2'd3; cfg_idx = 3'd1; cfg_data = 16'd777; end
      if (c == 4) begin cfg_we = 1'b1; cfg_preset = 2'd1; cfg_idx = 3'd6; cfg_data = 16'd5; end
      sample_tick = (c == 10);
      step();
      if (c == 2) check_val("dir_wr_err", {31'd0, cfg_wr_err}, 1);
      if (c == 3) check_val("dir_wr_ok", {31'd0, cfg_wr_err}, 0);
    end
    check_val("dir_coll_b0", b0, 15871);
    load_fast(3);
    check_val("dir_p3_b1", b1, 777);

    // Extra request while busy is ignored; early tick forgotten; swap at 41
    load_req = 1'b1; load_preset = 2'd2; step();
    for (int c = 1; c <= 40; c++) begin
      load_req    = (c == 3);
      load_preset = 2'd1;
      sample_tick = (c == 4) || (c == 40);
      step();
      if (c == 39) check_val("dir_wait_busy", {31'd0, busy}, 1);
    end
    check_val("dir_c41_ack", {31'd0, load_ack}, 1);
    check_val("dir_c41_ap", {30'd0, active_preset}, 2);

    // Reset in WAIT_TICK; preset 1 must come back as passthrough
    load_req = 1'b1; load_preset = 2'd1; step();
    for (int c = 1; c <= 9; c++) step();
    reset = 1'b1; step();
    reset = 1'b0;
    check_val("dir_mid_rst_b0", b0, 16384);
    check_val("dir_mid_rst_ack", {31'd0, load_ack}, 0);
    write_set(2, 15871, -30917, 15106, -30906, 14618);
    load_fast(2);
    load_fast(1);
    check_val("dir_p1_unity_b0", b0, 16384);
    check_val("dir_p1_unity_b1", b1, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 599) == 0);
      cfg_we      = ($urandom_range(0, 9) < 3);
      cfg_preset  = PW'($urandom_range(0, NP - 1));
      cfg_idx     = 3'($urandom_range(0, 7));
      rd          = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                                : int'($urandom_range(0, 32767)) - 16384;
      cfg_data    = 16'(rd);
      load_req    = ($urandom_range(0, 9) == 0);
      load_preset = PW'($urandom_range(0, NP - 1));
      sample_tick = ($urandom_range(0, 15) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
